pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised, handshaked pipeline stage register that replaces the fixed stall-vector/discard stage registers between decode and execute, and is reusable at any stage boundary.
- Carries a PC, an opaque payload and a branch-prediction bit under valid/ready flow control.
- Optional skid entry so upstream in_ready has no combinational path from out_ready.
- Synchronous flush for branch-mispredict discard.
- Saturating stall and bubble performance counters.

Parameters:
PC_W, 32, width of the pc field
PAYLOAD_W, 96, width of the opaque payload (alusel/aluop/op1/op2/etc. packed by the instantiating stage)
SKID, 1, 1 = two-entry skid buffer; 0 = single entry with combinational ready pass-through
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream entry present
in_ready  output  1  stage accepts the entry this cycle
in_pc  input  PC_W  upstream pc
in_payload  input  PAYLOAD_W  upstream payload
in_pred  input  1  upstream prediction bit
flush  input  1  discard all held entries (mispredict from EX)
out_valid  output  1  downstream entry present
out_ready  input  1  downstream accepts the entry
out_pc  output  PC_W  held pc
out_payload  output  PAYLOAD_W  held payload
out_pred  output  1  held prediction bit
occupancy  output  2  entries held (0..2; max 1 when SKID=0)
cnt_clr  input  1  synchronous clear of both counters
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1

Behaviour:
Handshake and transfers
- A transfer occurs when valid and ready are both 1 on a clock edge.
- in_valid and payload are held by upstream until accepted.

Reset
- rst asserts asynchronously:
  - main and skid entries invalid;
  - out_pc, out_payload, out_pred = 0;
  - out_valid = 0, occupancy = 0;
  - both counters = 0.
- Reset mid-transfer drops everything; nothing is replayed.

Empty entries
- When out_valid=0, out_pc, out_payload and out_pred read 0, so bubbles are zero-filled.

Latency
- 1 cycle from in transfer to out_valid when the stage is empty.

SKID=1, states EMPTY(occ 0) / ONE(occ 1) / FULL(occ 2)
- in_ready = !skid_valid && !flush. This is registered-derived, with no path from out_ready.
- EMPTY:
  - in transfer -> main <= in, ONE.
- ONE:
  - out_ready && in transfer -> main <= in, stay ONE.
  - out_ready only -> EMPTY.
  - in transfer only -> skid <= in, FULL.
  - neither -> hold.
- FULL:
  - out_ready -> main <= skid, skid cleared, ONE.
  - otherwise hold.
- Order is strictly preserved; the skid entry is always older than any new input.

SKID=0
- Single entry.
- in_ready = (!main_valid || out_ready) && !flush. This path is combinational from out_ready.
- Simultaneous out and in transfer replaces main in the same edge.

Flush
- Highest priority after reset.
- On an edge with flush=1:
  - both entries invalidated and data zeroed;
  - occupancy = 0;
  - any in_valid that cycle is not accepted (in_ready=0).
- out_valid may be 1 during the flush cycle. Downstream must qualify with its own flush.

Counters
- Increment by 1 per qualifying cycle.
- Saturate at 2^CNT_W-1.
- cnt_clr has priority over an increment on the same edge (result 0).
- Counters are unaffected by flush.

Test Plan:
1. Streaming, SKID=1, out_ready=1, in pcs 0x0,0x4,0x8,0xC back-to-back -> out_pc 0x0..0xC each one cycle later; in_ready stays 1; stall_cnt=0.
2. Backpressure, SKID=1, send A=0x100,B=0x104,C=0x108 with out_ready=0 for 3 cycles:
   - A held on out; B goes to skid; occupancy=2; in_ready=0, so C is held upstream.
   - Release out_ready -> A,B,C emerge in order; stall_cnt=3.
3. Flush in FULL with in_valid=1 (pc 0x200) -> next cycle out_valid=0, occupancy=0, out_pc=0; 0x200 never appears on the output.
4. Async reset mid-operation: occupancy=2, assert rst between edges -> out_valid, out_pc and counters are 0 before the next edge.
5. CNT_W=4: 20 stall cycles -> stall_cnt=15. Then cnt_clr together with a stall cycle -> 0. Then 2 bubble cycles -> bubble_cnt=2.
6. SKID=0: main full, out_ready toggles 1/0 -> in_ready follows out_ready the same cycle; a simultaneous in/out transfer keeps occupancy=1 with the new pc on the output.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register: main entry plus optional skid entry,
// synchronous flush, and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int PC_W      = 32,
  parameter int PAYLOAD_W = 96,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_pred,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_pred,
  output logic [1:0]           occupancy,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [PAYLOAD_W-1:0] payload;
    logic                 pred;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, in_ent;
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
  logic             in_xfer;

  assign in_ent  = '{pc: in_pc, payload: in_payload, pred: in_pred};
  assign in_xfer = in_valid && in_ready;

  // With a skid slot, in_ready depends only on registered state; without it,
  // a full main entry can still accept when downstream drains the same cycle.
  always_comb begin
    if (SKID != 0) in_ready = (state_q != FULL) && !flush;
    else           in_ready = ((state_q == EMPTY) || out_ready) && !flush;
  end

  // Vacated entries are zeroed so bubbles present all-zero data downstream.
  // For SKID=0, in_xfer with out_ready=0 cannot occur in ONE, so FULL is unreachable.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          main_d  = in_ent;
          state_d = ONE;
        end
        ONE: begin
          if (out_ready && in_xfer) begin
            main_d = in_ent;
          end else if (out_ready) begin
            main_d  = '0;
            state_d = EMPTY;
          end else if (in_xfer) begin
            skid_d  = in_ent;
            state_d = FULL;
          end
        end
        FULL: if (out_ready) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (cnt_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1))  stall_d  = stall_q + CNT_W'(1);
      if (!out_valid && out_ready && (bubble_q != '1)) bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_valid   = (state_q != EMPTY);
  assign out_pc      = main_q.pc;
  assign out_payload = main_q.payload;
  assign out_pred    = main_q.pred;
  assign occupancy   = state_q;
  assign stall_cnt   = stall_q;
  assign bubble_cnt  = bubble_q;

endmodule
